// File: rtl/alu_status_buffer.sv
// Small circular FIFO for adder results and flags, with sticky flag
// accumulation and a free-running count of accepted entries.
module alu_status_buffer #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     S,
  input  logic            C,
  input  logic            Zero,
  input  logic            Negative,
  input  logic            Overflow,
  input  logic [3:0]      f,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_S,
  output logic            out_C,
  output logic            out_Z,
  output logic            out_N,
  output logic            out_V,
  output logic [3:0]      out_f,
  input  logic            clr_sticky,
  output logic            sticky_C,
  output logic            sticky_Z,
  output logic            sticky_N,
  output logic            sticky_V,
  output logic [CNTW-1:0] acc_count,
  output logic            full,
  output logic            empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  fl;   // {C, Z, N, V}
    logic [3:0]  f;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, last_ptr;
  logic [OW-1:0]   occ;
  logic [3:0]      sticky;
  logic            push, pop;
  entry_t          in_ent, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (occ == OW'(DEPTH));
  assign empty     = (occ == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_ent    = '{s: S, fl: {C, Zero, Negative, Overflow}, f: f};

  // When empty, the slot behind rd_ptr still holds the last popped entry,
  // and a push into an empty buffer writes at rd_ptr, so it stays intact.
  assign last_ptr = (rd_ptr == '0) ? PW'(DEPTH - 1) : rd_ptr - PW'(1);
  assign head     = empty ? mem[last_ptr] : mem[rd_ptr];

  assign out_S = head.s;
  assign {out_C, out_Z, out_N, out_V} = head.fl;
  assign out_f = head.f;
  assign {sticky_C, sticky_Z, sticky_N, sticky_V} = sticky;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      acc_count <= '0;
      sticky    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_ent;
        wr_ptr      <= ptr_inc(wr_ptr);
        acc_count   <= acc_count + CNTW'(1);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      // A clear coinciding with a push keeps only the incoming flags.
      if (clr_sticky)  sticky <= push ? in_ent.fl : 4'b0;
      else if (push)   sticky <= sticky | in_ent.fl;
    end
  end
endmodule

// File: tb/tb_alu_status_buffer.sv
// Scoreboard bench: expected entries are queued when pushes are driven and
// compared against the head outputs every cycle, alongside status/counters.
module tb_alu_status_buffer;
  localparam int DEPTH = 2;
  localparam int CNTW  = 4;

  logic            clk = 0;
  logic            rst_n, in_valid, in_ready, C, Zero, Negative, Overflow;
  logic [31:0]     S, out_S;
  logic [3:0]      f, out_f;
  logic            out_valid, out_ready, out_C, out_Z, out_N, out_V;
  logic            clr_sticky, sticky_C, sticky_Z, sticky_N, sticky_V, full, empty;
  logic [CNTW-1:0] acc_count;

  alu_status_buffer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .C(C), .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .f(f),
    .out_valid(out_valid), .out_ready(out_ready), .out_S(out_S),
    .out_C(out_C), .out_Z(out_Z), .out_N(out_N), .out_V(out_V), .out_f(out_f),
    .clr_sticky(clr_sticky), .sticky_C(sticky_C), .sticky_Z(sticky_Z),
    .sticky_N(sticky_N), .sticky_V(sticky_V), .acc_count(acc_count),
    .full(full), .empty(empty));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic [3:0]  fl;
    logic [3:0]  f;
  } ent_t;

  ent_t            q[$];
  ent_t            last;
  logic [3:0]      m_sticky;
  logic [CNTW-1:0] m_acc;
  int              n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : last;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("empty",     64'(empty),     64'(q.size() == 0));
    chk("full",      64'(full),      64'(q.size() == DEPTH));
    chk("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
    chk("acc_count", 64'(acc_count), 64'(m_acc));
    chk("sticky",    64'({sticky_C, sticky_Z, sticky_N, sticky_V}), 64'(m_sticky));
    chk("head",      64'({out_S, out_C, out_Z, out_N, out_V, out_f}), 64'(h));
  endtask

  // One clock: drive inputs, advance the model with the pre-edge state, check.
  task automatic cyc(input logic rst, input logic iv, input logic [31:0] s,
                     input logic [3:0] fl, input logic [3:0] fc,
                     input logic ordy, input logic clr);
    logic psh, pp;
    ent_t e;
    rst_n = ~rst; in_valid = iv; S = s; {C, Zero, Negative, Overflow} = fl;
    f = fc; out_ready = ordy; clr_sticky = clr;
    e   = '{s: s, fl: fl, f: fc};
    psh = !rst && iv && (q.size() < DEPTH);
    pp  = !rst && ordy && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete(); last = '0; m_sticky = '0; m_acc = '0;
    end else begin
      if (pp) last = q.pop_front();
      if (psh) begin
        q.push_back(e);
        m_acc = m_acc + 1'b1;
      end
      if (clr)      m_sticky = psh ? fl : 4'b0;
      else if (psh) m_sticky = m_sticky | fl;
    end
    #1 check_all();
  endtask

  task automatic idle(input logic ordy);
    cyc(0, 0, 32'hDEAD_BEEF, 4'hF, 4'hF, ordy, 0);
  endtask

  initial begin
    last = '0; m_sticky = '0; m_acc = '0;
    cyc(1, 1, 32'h1234, 4'hF, 4'h3, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Zero-result entry, held while out_ready is low, then drained
    cyc(0, 1, 32'h0, 4'b0100, 4'b0101, 0, 0);
    idle(0);
    idle(1);
    idle(1);

    // Fill to full; third push must be refused
    cyc(0, 1, 32'd1, 4'b0000, 4'h1, 0, 0);
    cyc(0, 1, 32'd2, 4'b0010, 4'h2, 0, 0);
    cyc(0, 1, 32'd3, 4'b1000, 4'h3, 0, 0);
    idle(1);
    idle(1);

    // Full buffer with push and pop together: pop only
    cyc(0, 1, 32'd10, 4'b0000, 4'h4, 0, 0);
    cyc(0, 1, 32'd11, 4'b0000, 4'h5, 0, 0);
    cyc(0, 1, 32'd12, 4'b0001, 4'h6, 1, 0);
    cyc(0, 1, 32'd13, 4'b0000, 4'h7, 1, 0);
    idle(1);
    idle(1);

    // Sticky clear coinciding with a push
    cyc(0, 1, 32'd20, 4'b0001, 4'h8, 1, 0);
    cyc(0, 1, 32'd21, 4'b1000, 4'h9, 1, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 1);

    // 17 streaming pushes wrap the 4-bit counter
    for (int i = 0; i < 17; i++)
      cyc(0, 1, 32'd100 + 32'(i), 4'($urandom_range(0, 15)), 4'(i), 1, 0);
    idle(1);

    // Reset with entries buffered discards them
    cyc(0, 1, 32'hAAAA_0001, 4'b1111, 4'hA, 0, 0);
    cyc(0, 1, 32'hAAAA_0002, 4'b0101, 4'hB, 0, 0);
    cyc(1, 1, 32'hAAAA_0003, 4'b1111, 4'hC, 1, 1);
    idle(1);
    cyc(0, 1, 32'h0000_ABCD, 4'b0010, 4'hD, 0, 0);
    idle(1);
    idle(1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      cyc(0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_status_buffer.md
ALU_STATUS_BUFFER -- requirements
Module: alu_status_buffer

Interface
REQ-001 The block SHALL define parameter DEPTH, default 2, as the number of buffered result entries (legal values 2 or 4).
REQ-002 The block SHALL define parameter CNTW, default 16, as the width of the accepted-result counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream adder result and flags are valid this cycle.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 S  input  32  adder sum.
REQ-008 C  input  1  adder carry-out.
REQ-009 Zero, Negative, Overflow  input  1 each  adder status flags.
REQ-010 f  input  4  function code {f3,f2,f1,f0} that produced the result.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  downstream accepts the head entry.
REQ-013 out_S  output  32  head entry sum.
REQ-014 out_C, out_Z, out_N, out_V  output  1 each  head entry flags.
REQ-015 out_f  output  4  head entry function code.
REQ-016 clr_sticky  input  1  one-cycle pulse clearing sticky flags.
REQ-017 sticky_C, sticky_Z, sticky_N, sticky_V  output  1 each  OR of flags over all accepted entries since last clear.
REQ-018 acc_count  output  CNTW  number of entries accepted since reset, modulo 2^CNTW.
REQ-019 full, empty  output  1 each  buffer occupancy status.

Function
REQ-020 Push SHALL occur when in_valid and in_ready are both high at a rising edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-021 in_ready SHALL equal NOT full, registered-state derived only, with no combinational path from out_ready.
REQ-022 The buffer SHALL be a circular FIFO with separate read/write pointers wrapping from DEPTH-1 to 0, and an occupancy count from 0 to DEPTH.
REQ-023 Latency SHALL be one cycle: an entry pushed into an empty buffer at edge N appears with out_valid high after edge N.
REQ-024 out_S, out_C, out_Z, out_N, out_V, out_f SHALL present the oldest entry; their value is held stable while out_valid is high and out_ready is low.
REQ-025 Simultaneous push and pop on a non-empty, non-full buffer SHALL leave occupancy unchanged and preserve order.
REQ-026 When full, push SHALL be blocked even if a pop occurs the same cycle; in_valid without in_ready SHALL have no effect.
REQ-027 When empty, out_valid SHALL be low and out_ready SHALL be ignored; outputs hold their last values.
REQ-028 On every push, sticky flags SHALL update as sticky_X <= sticky_X OR incoming flag (C, Zero, Negative, Overflow respectively).
REQ-029 clr_sticky SHALL zero all sticky flags; if a push coincides with clr_sticky, sticky flags SHALL equal the incoming entry's flags only.
REQ-030 acc_count SHALL increment by 1 on every push and wrap from 2^CNTW-1 to 0.
REQ-031 full SHALL be high exactly when occupancy = DEPTH; empty SHALL be high exactly when occupancy = 0.

Reset
REQ-032 While rst_n is low at a rising edge: pointers, occupancy, acc_count and sticky flags SHALL be 0; out_valid=0, in_ready=1, empty=1, full=0; out_S=0, out_f=0, out_C/Z/N/V=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries at that edge; in_valid, out_ready and clr_sticky SHALL be ignored during reset.
REQ-034 Outputs SHALL remain at reset values until the first push after rst_n returns high.

Verification
REQ-035 Reset, then push S=0x00000000, Zero=1, f=0101 with out_ready=0 -> next cycle out_valid=1, out_S=0, out_Z=1, sticky_Z=1, acc_count=1, empty=0.
REQ-036 DEPTH=2, out_ready=0, push 3 consecutive entries (S=1,2,3) -> full=1 and in_ready=0 after second push; third not accepted; acc_count=2; draining yields 1 then 2.
REQ-037 Full buffer, in_valid=1 and out_ready=1 same cycle -> one pop, no push; occupancy DEPTH-1, in_ready=1 next cycle.
REQ-038 Push Overflow=1 entry, then pulse clr_sticky together with push of Carry=1, Overflow=0 -> sticky_V=0, sticky_C=1.
REQ-039 CNTW=4, perform 17 pushes with out_ready=1 -> acc_count=1, stream order preserved, no entry lost.
REQ-040 Two entries buffered, assert rst_n=0 one cycle -> out_valid=0, empty=1, acc_count=0, sticky flags 0; next pushed entry emerges first.
